univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits; legal range is 2..32.
REQ-002 The block SHALL have parameter RST_VAL, default 0 (WIDTH bits), meaning the value loaded into q on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: a high level qualifies the mode operation on the current edge.
REQ-006 The block SHALL have port mode, input, 2 bits, encoded as follows: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port sin_r, input, 1 bit: the serial bit that enters q[WIDTH-1] on a right shift.
REQ-008 The block SHALL have port sin_l, input, 1 bit: the serial bit that enters q[0] on a left shift.
REQ-009 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-011 The block SHALL have port sout_r, output, 1 bit, equal to q[0], which is the bit leaving on a right shift.
REQ-012 The block SHALL have port sout_l, output, 1 bit, equal to q[WIDTH-1], which is the bit leaving on a left shift.
REQ-013 The block SHALL have port nand_out, output, 1 bit: the combinational NAND of all q bits (~&q).
REQ-014 The block SHALL have port done, output, 1 bit: a registered one-cycle pulse marking WIDTH completed shifts since the last load or reset.

Function
REQ-015 With en=0, q, the shift counter and all other state SHALL hold on every edge, and done SHALL be 0 in the next cycle.
REQ-016 With en=1 and mode=00, q and the counter SHALL hold, and done SHALL be 0 in the next cycle.
REQ-017 With en=1 and mode=01, q SHALL become {sin_r, q[WIDTH-1:1]} on the edge.
REQ-018 With en=1 and mode=10, q SHALL become {q[WIDTH-2:0], sin_l} on the edge.
REQ-019 With en=1 and mode=11, q SHALL become d on the edge, and the shift counter SHALL clear to 0.
REQ-020 The block SHALL keep an internal shift counter cnt of width $clog2(WIDTH+1), counting qualified shifts in either direction; mixed directions SHALL accumulate.
REQ-021 On a qualified shift when cnt = WIDTH-1, cnt SHALL wrap to 0 and done SHALL be 1 for exactly the following cycle.
REQ-022 On a qualified shift with any other cnt value, cnt SHALL increment by 1 and done SHALL be 0.
REQ-023 done SHALL never be high for two consecutive cycles unless two consecutive qualified shifts each complete a WIDTH-shift group, which requires WIDTH=1 and is therefore excluded.
REQ-024 Outputs sout_r, sout_l and nand_out SHALL be purely combinational from q, with zero cycles of latency.
REQ-025 Operation latency SHALL be one edge for load and shift, with the q update visible immediately after the edge.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, independent of clk, set q=RST_VAL, cnt=0 and done=0.
REQ-027 Assertion of rst_n mid-shift-group SHALL discard the partial count, so that a full WIDTH new shifts are needed for done.
REQ-028 The first qualified edge after rst_n rises SHALL operate normally, with no dead cycle.

Verification (WIDTH=8, RST_VAL=0)
REQ-029 Reset: load 0x5A, 3 shifts, then pulse rst_n low between edges -> q=0x00 at once, nand_out=1, done=0; 8 further shifts are needed to raise done.
REQ-030 Right shift: load 0xA5, then mode=01 with sin_r=1 for one edge -> q=0xD2, sout_r=0, sout_l=1.
REQ-031 Left shift and done: load 0x0F, then 8 edges of mode=10 with sin_l=0 -> q=0x00 after the 8th edge, done=1 for exactly the one cycle after the 8th edge, and 0 otherwise.
REQ-032 NAND output: load 0xFF -> nand_out=0; then one right shift with sin_r=0 -> q=0x7F, nand_out=1.
REQ-033 Enable and counter reload: en=0 with mode=11 and d=0x33 -> q unchanged; then 4 shifts, a load of 0x33, and 8 shifts -> done pulses only after the 8th post-load shift.
REQ-034 Mixed direction: load 0x81, then 3 right and 5 left shifts with both serial inputs at 0 -> done pulses after the 8th shift, and q=0x00.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a registered pulse after every WIDTH qualified shifts since the last load or reset.
module univ_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             nand_out,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] M_HOLD  = 2'b00;
   localparam logic [1:0] M_SHR   = 2'b01;
   localparam logic [1:0] M_SHL   = 2'b10;
   localparam logic [1:0] M_LOAD  = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shift;

   assign shift = en && ((mode == M_SHR) || (mode == M_SHL));

   always_comb begin
      q_d    = q_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (en) begin
         unique case (mode)
            M_HOLD: ;
            M_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
            M_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
            M_LOAD: begin
               q_d   = d;
               cnt_d = '0;
            end
            default: ;
         endcase
      end
      // Direction doesn't matter: any shift advances the group count.
      if (shift) begin
         if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= RST_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q        = q_q;
   assign sout_r   = q_q[0];
   assign sout_l   = q_q[WIDTH-1];
   assign nand_out = ~&q_q;
   assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RST_VAL=0) with hand-computed expectations.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic       sin_r, sin_l;
   logic [7:0] d;
   logic [7:0] q;
   logic       sout_r, sout_l, nand_out, done;

   int total = 0;
   int fails = 0;

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
      .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l), .nand_out(nand_out), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one rising edge, then settle 1 time unit.
   task automatic step(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [7:0] dd);
      en = e; mode = m; sin_r = sr; sin_l = sl; d = dd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; d = 8'h00;
      #2;
      chk("rst_q", q, 8'h00);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_nand", {7'd0, nand_out}, 8'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset mid-group: partial count discarded
      step(1, 2'b11, 0, 0, 8'h5A);
      chk("ld5A_q", q, 8'h5A);
      step(1, 2'b01, 0, 0, 8'h00);
      step(1, 2'b01, 0, 0, 8'h00);
      step(1, 2'b01, 0, 0, 8'h00);
      chk("shr3_q", q, 8'h0B);
      rst_n = 1'b0;
      #2;
      chk("midrst_q", q, 8'h00);
      chk("midrst_nand", {7'd0, nand_out}, 8'd1);
      chk("midrst_done", {7'd0, done}, 8'd0);
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step(1, 2'b01, 1, 0, 8'h00);
         chk($sformatf("postrst_done%0d", i), {7'd0, done}, (i == 8) ? 8'd1 : 8'd0);
      end
      chk("postrst_q", q, 8'hFF);
      step(1, 2'b00, 0, 0, 8'h00);
      chk("postrst_done_clr", {7'd0, done}, 8'd0);

      // Right shift
      step(1, 2'b11, 0, 0, 8'hA5);
      step(1, 2'b01, 1, 0, 8'h00);
      chk("shr_q", q, 8'hD2);
      chk("shr_sout_r", {7'd0, sout_r}, 8'd0);
      chk("shr_sout_l", {7'd0, sout_l}, 8'd1);

      // Left shift, done after 8th
      step(1, 2'b11, 0, 0, 8'h0F);
      for (int i = 1; i <= 8; i++) begin
         step(1, 2'b10, 0, 0, 8'h00);
         if (i == 4) chk("shl4_q", q, 8'hF0);
         chk($sformatf("shl_done%0d", i), {7'd0, done}, (i == 8) ? 8'd1 : 8'd0);
      end
      chk("shl8_q", q, 8'h00);
      step(1, 2'b00, 0, 0, 8'h00);
      chk("shl_done_clr", {7'd0, done}, 8'd0);

      // NAND output
      step(1, 2'b11, 0, 0, 8'hFF);
      chk("ldFF_nand", {7'd0, nand_out}, 8'd0);
      step(1, 2'b01, 0, 0, 8'h00);
      chk("shr7F_q", q, 8'h7F);
      chk("shr7F_nand", {7'd0, nand_out}, 8'd1);

      // Enable gating and counter reload
      step(0, 2'b11, 0, 0, 8'h33);
      chk("en0_q", q, 8'h7F);
      chk("en0_done", {7'd0, done}, 8'd0);
      for (int i = 0; i < 4; i++) step(1, 2'b10, 0, 1, 8'h00);
      step(1, 2'b11, 0, 0, 8'h33);
      chk("reld_q", q, 8'h33);
      step(1, 2'b00, 0, 0, 8'h00);
      chk("hold_q", q, 8'h33);
      chk("hold_done", {7'd0, done}, 8'd0);
      for (int i = 1; i <= 8; i++) begin
         step(1, 2'b10, 0, 1, 8'h00);
         chk($sformatf("reld_done%0d", i), {7'd0, done}, (i == 8) ? 8'd1 : 8'd0);
      end
      chk("reld8_q", q, 8'hFF);

      // Mixed direction accumulates
      step(1, 2'b11, 0, 0, 8'h81);
      for (int i = 1; i <= 8; i++) begin
         step(1, (i <= 3) ? 2'b01 : 2'b10, 0, 0, 8'h00);
         if (i == 3) chk("mix3_q", q, 8'h10);
         chk($sformatf("mix_done%0d", i), {7'd0, done}, (i == 8) ? 8'd1 : 8'd0);
      end
      chk("mix8_q", q, 8'h00);
      step(0, 2'b01, 1, 1, 8'h00);
      chk("mix_done_clr", {7'd0, done}, 8'd0);
      chk("mix_en0_q", q, 8'h00);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
